// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and helpers for the stream FIFO
package stream_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
    } fifo_status_t;

    function automatic int lvl_w(int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_if.sv
// rtl/stream_if.sv - valid/ready beat interface with last marker
interface stream_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport tx (output valid, data, last, input ready);
    modport rx (input valid, data, last, output ready);
endinterface

// File: rtl/stream_fifo_mem.sv
// rtl/stream_fifo_mem.sv - register file, synchronous write and asynchronous read
module stream_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through buffer between two stream_if views
module stream_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    stream_if.rx                     s,
    stream_if.tx                     m,
    output logic [lvl_w(DEPTH)-1:0]  o_level,
    output fifo_status_t             o_status
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic [LW-1:0]  next_level;
    logic           s_ready_q;
    logic           m_valid_q;
    logic           push;
    logic           pop;
    logic [WIDTH:0] rd_data;

    assign push = s.valid && s_ready_q;
    assign pop  = m_valid_q && m.ready;

    always_comb begin
        next_level = level;
        case ({push, pop})
            2'b10:   next_level = level + LW'(1);
            2'b01:   next_level = level - LW'(1);
            default: next_level = level;
        endcase
    end

    // Handshake flags are registered from next_level so neither side sees a
    // combinational path from the other; a full FIFO never passes through.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level     <= next_level;
            s_ready_q <= (next_level != LVL_FULL);
            m_valid_q <= (next_level != '0);
        end
    end

    stream_fifo_mem #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({s.last, s.data}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign s.ready  = s_ready_q;
    assign m.valid  = m_valid_q;
    assign m.last   = rd_data[WIDTH];
    assign m.data   = rd_data[WIDTH-1:0];

    assign o_level              = level;
    assign o_status.full        = (level == LVL_FULL);
    assign o_status.empty       = (level == '0);
    assign o_status.almost_full = (level >= LVL_AF);
endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - self-checking bench for stream_fifo
module tb_stream_fifo;
    import stream_pkg::*;

    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic [2:0]   level;
    fifo_status_t status;

    stream_if #(.WIDTH(8)) s_if ();
    stream_if #(.WIDTH(8)) m_if ();

    int vectors;
    int errors;
    logic [8:0] q[$];

    stream_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(3)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .s        (s_if),
        .m        (m_if),
        .o_level  (level),
        .o_status (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input logic sv, input logic [7:0] sd, input logic sl, input logic mr);
        bit push, pop;
        logic [8:0] tmp;
        s_if.valid = sv;
        s_if.data  = sd;
        s_if.last  = sl;
        m_if.ready = mr;
        push = sv && (q.size() < DEPTH);
        pop  = mr && (q.size() != 0);
        @(posedge clk);
        if (pop) tmp = q.pop_front();
        if (push) q.push_back({sl, sd});
        @(negedge clk);
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0; m_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (m_if.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", m_if.valid); end
        vectors++;
        if (s_if.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", s_if.ready); end
        vectors++;
        if (level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
        vectors++;
        if (status !== 3'b010) begin errors++; $display("FAIL rst_status got=%b exp=010", status); end
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_single_beat();
        tick(1'b1, 8'hA5, 1'b1, 1'b0);
        vectors++;
        if ({m_if.valid, m_if.last, m_if.data} !== {1'b1, 1'b1, 8'hA5}) begin
            errors++; $display("FAIL single_out got=%b/%b/%h exp=1/1/a5", m_if.valid, m_if.last, m_if.data);
        end
        vectors++;
        if (level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (m_if.valid !== 1'b0 || status.empty !== 1'b1) begin
            errors++; $display("FAIL single_pop got=%b/%b exp=0/1", m_if.valid, status.empty);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b0);
            vectors++;
            if (level !== 3'(i) || status.almost_full !== (i >= 3) || status.full !== (i == 4) ||
                s_if.ready !== (i != 4)) begin
                errors++;
                $display("FAIL fill_%0d got lvl=%0d af=%b full=%b rdy=%b exp lvl=%0d af=%b full=%b rdy=%b",
                         i, level, status.almost_full, status.full, s_if.ready, i, i >= 3, i == 4, i != 4);
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 8'h05, 1'b0, 1'b0);
            vectors++;
            if (level !== 3'd4) begin errors++; $display("FAIL overflow_level got=%0d exp=4", level); end
        end
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (m_if.valid !== 1'b1 || m_if.data !== 8'(i)) begin
                errors++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, m_if.valid, m_if.data, 8'(i));
            end
            tick(1'b0, 8'h00, 1'b0, 1'b1);
        end
        vectors++;
        if (status !== 3'b010) begin errors++; $display("FAIL drain_empty got=%b exp=010", status); end
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, 8'(8'h10 + k), 1'b0, 1'b1);
            vectors++;
            if (m_if.valid !== 1'b1 || m_if.data !== 8'(8'h10 + k) || level !== 3'd1) begin
                errors++;
                $display("FAIL stream_%0d got=%b/%h/%0d exp=1/%h/1", k, m_if.valid, m_if.data, level, 8'(8'h10 + k));
            end
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        tick(1'b1, 8'h30, 1'b0, 1'b0);
        tick(1'b1, 8'h31, 1'b0, 1'b0);
        tick(1'b1, 8'h32, 1'b0, 1'b1);
        vectors++;
        if (level !== 3'd2 || m_if.data !== 8'h31) begin
            errors++; $display("FAIL simul got=%0d/%h exp=2/31", level, m_if.data);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_if.valid !== 1'b0 || level !== 3'd0 || s_if.ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/1", m_if.valid, level, s_if.ready);
        end
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 8'h7E, 1'b0, 1'b0);
        vectors++;
        if (m_if.valid !== 1'b1 || m_if.data !== 8'h7E || m_if.last !== 1'b0 || level !== 3'd1) begin
            errors++; $display("FAIL mid_first got=%b/%h/%b/%0d exp=1/7e/0/1", m_if.valid, m_if.data, m_if.last, level);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0 ? c[5] : 1'b0));
            vectors++;
            if (m_if.valid !== (q.size() != 0) || s_if.ready !== (q.size() != DEPTH) ||
                level !== 3'(q.size()) ||
                status !== {q.size() == DEPTH, q.size() == 0, q.size() >= 3}) begin
                errors++;
                $display("FAIL rnd_ctl cyc=%0d got v=%b r=%b l=%0d st=%b exp l=%0d", c, m_if.valid,
                         s_if.ready, level, status, q.size());
            end
            if (q.size() != 0) begin
                vectors++;
                if ({m_if.last, m_if.data} !== q[0]) begin
                    errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, {m_if.last, m_if.data}, q[0]);
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single_beat();
        test_fill_overflow();
        test_streaming();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
